// File: rtl/peak_tracker_topn.sv
// Top-N peak tracker: keeps the NUM_PEAKS largest in-window magnitudes of a frame, then drains them largest first.
// Optional build macro PEAK_THRESHOLD_EN adds a per-cycle mag_threshold acceptance gate.
module peak_tracker_topn #(
    parameter int unsigned MAG_WIDTH = 96,
    parameter int unsigned K_WIDTH   = 11,
    parameter int unsigned NUM_PEAKS = 4,
    parameter int unsigned K_LO      = 0,
    parameter int unsigned K_HI      = (1 << K_WIDTH) - 1,
    localparam int unsigned RANK_W   = (NUM_PEAKS > 1) ? $clog2(NUM_PEAKS) : 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 frame_start,
    input  logic                 data_valid,
    input  logic [MAG_WIDTH-1:0] data_in,
    input  logic [K_WIDTH-1:0]   k_in,
    input  logic                 data_last,
`ifdef PEAK_THRESHOLD_EN
    input  logic [MAG_WIDTH-1:0] mag_threshold,
`endif
    output logic                 peak_valid,
    input  logic                 peak_ready,
    output logic [MAG_WIDTH-1:0] peak_mag,
    output logic [K_WIDTH-1:0]   peak_k,
    output logic [RANK_W-1:0]    peak_rank,
    output logic                 peak_occupied,
    output logic                 peak_last,
    output logic                 busy,
    output logic                 sample_dropped
);

    localparam int unsigned K_MAX = (1 << K_WIDTH) - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [MAG_WIDTH-1:0]   slot_mag_q [NUM_PEAKS];
    logic [MAG_WIDTH-1:0]   slot_mag_d [NUM_PEAKS];
    logic [K_WIDTH-1:0]     slot_k_q   [NUM_PEAKS];
    logic [K_WIDTH-1:0]     slot_k_d   [NUM_PEAKS];
    logic [NUM_PEAKS-1:0]   slot_occ_q, slot_occ_d;
    logic [RANK_W-1:0]      rank_q, rank_d;
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic                   busy_q, busy_d;
    logic                   dropped_q, dropped_d;
    logic [MAG_WIDTH-1:0]   out_mag_q, out_mag_d;
    logic [K_WIDTH-1:0]     out_k_q, out_k_d;
    logic                   out_occ_q, out_occ_d;

    logic                   lo_ok, hi_ok, thr_ok;
    logic                   scan_now, accept;
    logic [MAG_WIDTH-1:0]   base_mag [NUM_PEAKS];
    logic [K_WIDTH-1:0]     base_k   [NUM_PEAKS];
    logic [NUM_PEAKS-1:0]   base_occ;
    logic [MAG_WIDTH-1:0]   prev_mag [NUM_PEAKS];
    logic [K_WIDTH-1:0]     prev_k   [NUM_PEAKS];
    logic [NUM_PEAKS-1:0]   prev_occ;
    logic [NUM_PEAKS-1:0]   gt, prev_gt;

    // Window bounds that cover the whole index range reduce to constants.
    if (K_LO == 0) begin : g_lo_open
        assign lo_ok = 1'b1;
    end else begin : g_lo_cmp
        assign lo_ok = (k_in >= K_WIDTH'(K_LO));
    end

    if (K_HI >= K_MAX) begin : g_hi_open
        assign hi_ok = 1'b1;
    end else begin : g_hi_cmp
        assign hi_ok = (k_in <= K_WIDTH'(K_HI));
    end

`ifdef PEAK_THRESHOLD_EN
    assign thr_ok = (data_in >= mag_threshold);
`else
    assign thr_ok = 1'b1;
`endif

    // Sorted insertion: the list is descending with unoccupied slots at the tail,
    // so gt is a thermometer code and its first set bit is the insertion point.
    always_comb begin
        scan_now = frame_start || (state_q == ST_SCAN);
        accept   = scan_now && data_valid && lo_ok && hi_ok && thr_ok;

        for (int unsigned j = 0; j < NUM_PEAKS; j++) begin
            base_mag[j] = frame_start ? '0 : slot_mag_q[j];
            base_k[j]   = frame_start ? '0 : slot_k_q[j];
            base_occ[j] = frame_start ? 1'b0 : slot_occ_q[j];
            gt[j]       = !base_occ[j] || (base_mag[j] < data_in);
        end

        prev_mag[0] = '0;
        prev_k[0]   = '0;
        prev_occ[0] = 1'b0;
        prev_gt[0]  = 1'b0;
        for (int unsigned j = 1; j < NUM_PEAKS; j++) begin
            prev_mag[j] = base_mag[j-1];
            prev_k[j]   = base_k[j-1];
            prev_occ[j] = base_occ[j-1];
            prev_gt[j]  = gt[j-1];
        end

        for (int unsigned j = 0; j < NUM_PEAKS; j++) begin
            slot_mag_d[j] = base_mag[j];
            slot_k_d[j]   = base_k[j];
            slot_occ_d[j] = base_occ[j];
            if (accept && gt[j]) begin
                if (!prev_gt[j]) begin
                    slot_mag_d[j] = data_in;
                    slot_k_d[j]   = k_in;
                    slot_occ_d[j] = 1'b1;
                end else begin
                    slot_mag_d[j] = prev_mag[j];
                    slot_k_d[j]   = prev_k[j];
                    slot_occ_d[j] = prev_occ[j];
                end
            end
        end
    end

    // Next state, drain rank and registered output beat.
    always_comb begin
        state_d   = state_q;
        rank_d    = rank_q;
        dropped_d = data_valid && !frame_start && (state_q != ST_SCAN);

        unique case (state_q)
            ST_IDLE: begin
                if (frame_start) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (!frame_start && data_valid && data_last) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (frame_start) begin
                    state_d = ST_SCAN;
                end else if (valid_q && peak_ready) begin
                    if (last_q) state_d = ST_IDLE;
                    else        rank_d  = rank_q + RANK_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != ST_DRAIN) rank_d = '0;

        valid_d   = (state_d == ST_DRAIN);
        last_d    = valid_d && (rank_d == RANK_W'(NUM_PEAKS - 1));
        busy_d    = (state_d != ST_IDLE);
        out_mag_d = valid_d ? slot_mag_d[rank_d] : '0;
        out_k_d   = valid_d ? slot_k_d[rank_d]   : '0;
        out_occ_d = valid_d && slot_occ_d[rank_d];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            slot_occ_q <= '0;
            for (int unsigned j = 0; j < NUM_PEAKS; j++) begin
                slot_mag_q[j] <= '0;
                slot_k_q[j]   <= '0;
            end
            rank_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            dropped_q  <= 1'b0;
            out_mag_q  <= '0;
            out_k_q    <= '0;
            out_occ_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_occ_q <= slot_occ_d;
            for (int unsigned j = 0; j < NUM_PEAKS; j++) begin
                slot_mag_q[j] <= slot_mag_d[j];
                slot_k_q[j]   <= slot_k_d[j];
            end
            rank_q     <= rank_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
            dropped_q  <= dropped_d;
            out_mag_q  <= out_mag_d;
            out_k_q    <= out_k_d;
            out_occ_q  <= out_occ_d;
        end
    end

    assign peak_valid     = valid_q;
    assign peak_mag       = out_mag_q;
    assign peak_k         = out_k_q;
    assign peak_rank      = rank_q;
    assign peak_occupied  = out_occ_q;
    assign peak_last      = last_q;
    assign busy           = busy_q;
    assign sample_dropped = dropped_q;

endmodule

// File: tb/tb_peak_tracker_topn.sv
// Directed bench for peak_tracker_topn: a full-window instance and a K_LO=2..K_HI=5 instance share stimulus.
module tb_peak_tracker_topn;

    localparam int unsigned MW = 96;
    localparam int unsigned KW = 11;

    logic          clock;
    logic          reset_n;
    logic          frame_start;
    logic          data_valid;
    logic [MW-1:0] data_in;
    logic [KW-1:0] k_in;
    logic          data_last;
    logic          peak_ready;

    logic          pv, pocc, plast, pbusy, pdrop;
    logic [MW-1:0] pmag;
    logic [KW-1:0] pk;
    logic [1:0]    prank;

    logic          wv, wocc, wlast, wbusy, wdrop;
    logic [MW-1:0] wmag;
    logic [KW-1:0] wk;
    logic [1:0]    wrank;

    int n_pass  = 0;
    int n_total = 0;

    peak_tracker_topn dut (
        .clock(clock), .reset_n(reset_n), .frame_start(frame_start),
        .data_valid(data_valid), .data_in(data_in), .k_in(k_in), .data_last(data_last),
        .peak_valid(pv), .peak_ready(peak_ready), .peak_mag(pmag), .peak_k(pk),
        .peak_rank(prank), .peak_occupied(pocc), .peak_last(plast),
        .busy(pbusy), .sample_dropped(pdrop)
    );

    peak_tracker_topn #(.K_LO(2), .K_HI(5)) dut_w (
        .clock(clock), .reset_n(reset_n), .frame_start(frame_start),
        .data_valid(data_valid), .data_in(data_in), .k_in(k_in), .data_last(data_last),
        .peak_valid(wv), .peak_ready(peak_ready), .peak_mag(wmag), .peak_k(wk),
        .peak_rank(wrank), .peak_occupied(wocc), .peak_last(wlast),
        .busy(wbusy), .sample_dropped(wdrop)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic send(input int k, input int mag, input bit last);
        data_valid = 1'b1;
        k_in       = KW'(k);
        data_in    = MW'(mag);
        data_last  = last;
        step();
        data_valid = 1'b0;
        data_last  = 1'b0;
    endtask

    task automatic send_basic_frame();
        int mags[8] = '{5, 9, 2, 9, 1, 7, 3, 8};
        start_frame();
        for (int i = 0; i < 8; i++) send(i, mags[i], i == 7);
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        n_total++;
        if ({pv, pbusy, prank, plast, pdrop, pocc} !== 7'b0) begin
            $display("FAIL reset_outputs: got v=%b busy=%b rank=%0d last=%b drop=%b occ=%b, need all 0",
                     pv, pbusy, prank, plast, pdrop, pocc);
        end else n_pass++;
        n_total++;
        if (pmag !== '0 || pk !== '0) $display("FAIL reset_data: got mag=%0d k=%0d, need 0/0", pmag, pk);
        else n_pass++;
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_basic_sort();
        int em[4] = '{9, 9, 8, 7};
        int ek[4] = '{1, 3, 7, 5};
        peak_ready = 1'b1;
        send_basic_frame();
        for (int r = 0; r < 4; r++) begin
            n_total++;
            if (pv !== 1'b1 || pmag !== MW'(em[r]) || pk !== KW'(ek[r]) || prank !== 2'(r)
                || pocc !== 1'b1 || plast !== (r == 3)) begin
                $display("FAIL basic_rank%0d: got v=%b mag=%0d k=%0d rank=%0d occ=%b last=%b, need v=1 mag=%0d k=%0d rank=%0d occ=1 last=%0d",
                         r, pv, pmag, pk, prank, pocc, plast, em[r], ek[r], r, r == 3);
            end else n_pass++;
            step();
        end
        n_total++;
        if (pv !== 1'b0 || pbusy !== 1'b0) $display("FAIL basic_idle: got v=%b busy=%b, need 0/0", pv, pbusy);
        else n_pass++;
        peak_ready = 1'b0;
    endtask

    task automatic test_window();
        int wm[4] = '{5, 4, 3, 2};
        int fm[4] = '{10, 9, 8, 7};
        peak_ready = 1'b1;
        start_frame();
        for (int i = 0; i <= 10; i++) send(i, i, i == 10);
        for (int r = 0; r < 4; r++) begin
            n_total++;
            if (wv !== 1'b1 || wmag !== MW'(wm[r]) || wk !== KW'(wm[r]) || wocc !== 1'b1 || wrank !== 2'(r)) begin
                $display("FAIL window_rank%0d: got v=%b mag=%0d k=%0d occ=%b rank=%0d, need v=1 mag=%0d k=%0d occ=1 rank=%0d",
                         r, wv, wmag, wk, wocc, wrank, wm[r], wm[r], r);
            end else n_pass++;
            n_total++;
            if (pmag !== MW'(fm[r]) || pk !== KW'(fm[r])) begin
                $display("FAIL fullwin_rank%0d: got mag=%0d k=%0d, need mag=%0d k=%0d", r, pmag, pk, fm[r], fm[r]);
            end else n_pass++;
            step();
        end
        n_total++;
        if (wv !== 1'b0 || wbusy !== 1'b0) $display("FAIL window_idle: got v=%b busy=%b, need 0/0", wv, wbusy);
        else n_pass++;
        peak_ready = 1'b0;
    endtask

    task automatic test_sparse();
        int em[4]  = '{20, 10, 0, 0};
        int ek[4]  = '{6, 4, 0, 0};
        bit eo[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        peak_ready = 1'b1;
        start_frame();
        send(4, 10, 1'b0);
        send(6, 20, 1'b1);
        for (int r = 0; r < 4; r++) begin
            n_total++;
            if (pv !== 1'b1 || pmag !== MW'(em[r]) || pk !== KW'(ek[r]) || pocc !== eo[r] || plast !== (r == 3)) begin
                $display("FAIL sparse_rank%0d: got v=%b mag=%0d k=%0d occ=%b last=%b, need v=1 mag=%0d k=%0d occ=%0d last=%0d",
                         r, pv, pmag, pk, pocc, plast, em[r], ek[r], eo[r], r == 3);
            end else n_pass++;
            step();
        end
        n_total++;
        if (pv !== 1'b0) $display("FAIL sparse_idle: got v=%b, need 0", pv);
        else n_pass++;
        peak_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        peak_ready = 1'b0;
        send_basic_frame();
        n_total++;
        if (pv !== 1'b1 || prank !== 2'd0 || pmag !== MW'(9) || pk !== KW'(1)) begin
            $display("FAIL bp_rank0: got v=%b rank=%0d mag=%0d k=%0d, need v=1 rank=0 mag=9 k=1", pv, prank, pmag, pk);
        end else n_pass++;
        peak_ready = 1'b1;
        step();
        peak_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            data_valid = (c == 1);
            data_in    = MW'(1000);
            k_in       = KW'(0);
            step();
            data_valid = 1'b0;
            n_total++;
            if (pv !== 1'b1 || prank !== 2'd1 || pmag !== MW'(9) || pk !== KW'(3) || pocc !== 1'b1) begin
                $display("FAIL bp_hold%0d: got v=%b rank=%0d mag=%0d k=%0d occ=%b, need v=1 rank=1 mag=9 k=3 occ=1",
                         c, pv, prank, pmag, pk, pocc);
            end else n_pass++;
            n_total++;
            if (pdrop !== (c == 1)) $display("FAIL bp_dropped%0d: got %b, need %0d", c, pdrop, c == 1);
            else n_pass++;
        end
        peak_ready = 1'b1;
        step();
        n_total++;
        if (prank !== 2'd2 || pmag !== MW'(8) || pk !== KW'(7) || plast !== 1'b0) begin
            $display("FAIL bp_rank2: got rank=%0d mag=%0d k=%0d last=%b, need rank=2 mag=8 k=7 last=0", prank, pmag, pk, plast);
        end else n_pass++;
        step();
        n_total++;
        if (prank !== 2'd3 || pmag !== MW'(7) || pk !== KW'(5) || plast !== 1'b1) begin
            $display("FAIL bp_rank3: got rank=%0d mag=%0d k=%0d last=%b, need rank=3 mag=7 k=5 last=1", prank, pmag, pk, plast);
        end else n_pass++;
        step();
        n_total++;
        if (pv !== 1'b0 || pbusy !== 1'b0) $display("FAIL bp_idle: got v=%b busy=%b, need 0/0", pv, pbusy);
        else n_pass++;
        peak_ready = 1'b0;
    endtask

    task automatic test_abort_drain();
        peak_ready = 1'b1;
        send_basic_frame();
        step();
        step();
        n_total++;
        if (prank !== 2'd2) $display("FAIL abort_reach_rank2: got rank=%0d, need 2", prank);
        else n_pass++;
        start_frame();
        n_total++;
        if (pv !== 1'b0 || pbusy !== 1'b1) $display("FAIL abort_scan: got v=%b busy=%b, need v=0 busy=1", pv, pbusy);
        else n_pass++;
        send(3, 100, 1'b1);
        n_total++;
        if (pv !== 1'b1 || prank !== 2'd0 || pmag !== MW'(100) || pk !== KW'(3) || pocc !== 1'b1) begin
            $display("FAIL abort_new_rank0: got v=%b rank=%0d mag=%0d k=%0d occ=%b, need v=1 rank=0 mag=100 k=3 occ=1",
                     pv, prank, pmag, pk, pocc);
        end else n_pass++;
        step();
        n_total++;
        if (pocc !== 1'b0 || pmag !== '0 || pk !== '0) begin
            $display("FAIL abort_old_gone: got occ=%b mag=%0d k=%0d, need occ=0 mag=0 k=0", pocc, pmag, pk);
        end else n_pass++;
        repeat (3) step();
        n_total++;
        if (pv !== 1'b0 || pbusy !== 1'b0) $display("FAIL abort_idle: got v=%b busy=%b, need 0/0", pv, pbusy);
        else n_pass++;
        peak_ready = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        start_frame();
        send(0, 50, 1'b0);
        send(1, 60, 1'b0);
        send(2, 70, 1'b0);
        reset_n = 1'b0;
        #1;
        n_total++;
        if (pv !== 1'b0 || pbusy !== 1'b0) $display("FAIL midreset_outputs: got v=%b busy=%b, need 0/0", pv, pbusy);
        else n_pass++;
        #1;
        reset_n = 1'b1;
        step();
        n_total++;
        if (pbusy !== 1'b0) $display("FAIL midreset_idle: got busy=%b, need 0", pbusy);
        else n_pass++;
        peak_ready = 1'b1;
        start_frame();
        send(5, 3, 1'b1);
        n_total++;
        if (pv !== 1'b1 || pmag !== MW'(3) || pk !== KW'(5) || pocc !== 1'b1) begin
            $display("FAIL midreset_rank0: got v=%b mag=%0d k=%0d occ=%b, need v=1 mag=3 k=5 occ=1", pv, pmag, pk, pocc);
        end else n_pass++;
        step();
        n_total++;
        if (pocc !== 1'b0 || pmag !== '0) $display("FAIL midreset_rank1: got occ=%b mag=%0d, need occ=0 mag=0", pocc, pmag);
        else n_pass++;
        repeat (3) step();
        n_total++;
        if (pv !== 1'b0 || pbusy !== 1'b0) $display("FAIL midreset_idle_end: got v=%b busy=%b, need 0/0", pv, pbusy);
        else n_pass++;
        peak_ready = 1'b0;
    endtask

    initial begin
        reset_n     = 1'b1;
        frame_start = 1'b0;
        data_valid  = 1'b0;
        data_in     = '0;
        k_in        = '0;
        data_last   = 1'b0;
        peak_ready  = 1'b0;

        test_reset();
        test_basic_sort();
        test_window();
        test_sparse();
        test_backpressure();
        test_abort_drain();
        test_reset_mid_scan();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
